// File: rtl/ultrasound_tx_array_pkg.sv
// utx_pkg: shared defaults and types for the multi-channel ultrasound transmitter.
//   UTX_N_CH / UTX_PAT_W / UTX_HP_W / UTX_DLY_W : default geometry
//   ch_state_t : per-channel FSM state
//   utx_cfg_t  : transmission config snapshot handed from the top to every channel
//   utx_clamp_len() : limits a requested pattern length to UTX_PAT_W
package utx_pkg;

    localparam int UTX_N_CH  = 4;
    localparam int UTX_PAT_W = 32;
    localparam int UTX_HP_W  = 8;
    localparam int UTX_DLY_W = 12;
    localparam int UTX_LEN_W = $clog2(UTX_PAT_W) + 1;

    typedef enum logic [1:0] {
        CH_IDLE  = 2'd0,
        CH_DELAY = 2'd1,
        CH_TX    = 2'd2
    } ch_state_t;

    typedef struct packed {
        logic [UTX_PAT_W-1:0] pattern;
        logic [UTX_PAT_W-1:0] mask;
        logic [UTX_LEN_W-1:0] pat_len;
        logic [15:0]          pulse_len;
        logic [UTX_HP_W-1:0]  half_period;
    } utx_cfg_t;

    function automatic logic [UTX_LEN_W-1:0] utx_clamp_len(input logic [UTX_LEN_W-1:0] len);
        return (len > UTX_LEN_W'(UTX_PAT_W)) ? UTX_LEN_W'(UTX_PAT_W) : len;
    endfunction

endpackage

// File: rtl/ultrasound_tx_array_channel.sv
// utx_channel: one transducer channel. Waits its start delay, then plays the
// snapshot pattern bit by bit on a carrier of programmable half-period.
// Ports:
//   clk, rstn   clock, synchronous active-low reset
//   i_clear     abort to IDLE on the next edge (enable dropped)
//   i_start     accepted fire from the top
//   i_cfg       config snapshot (stable while this channel is busy)
//   i_delay     start delay in clocks (snapshot)
//   o_busy      channel in DELAY or TX
//   o_wave      registered drive output
module utx_channel
    import utx_pkg::*;
#(
    parameter int DLY_W = UTX_DLY_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_clear,
    input  logic             i_start,
    input  utx_cfg_t         i_cfg,
    input  logic [DLY_W-1:0] i_delay,
    output logic             o_busy,
    output logic             o_wave
);

    localparam int BIT_W = $clog2(UTX_PAT_W);

    ch_state_t              r_state,   w_state;
    logic [DLY_W-1:0]       r_dcnt,    w_dcnt;
    logic [UTX_HP_W-1:0]    r_hcnt,    w_hcnt;
    logic                   r_carrier, w_carrier;
    logic [16:0]            r_hcyc,    w_hcyc;     // half-periods elapsed in current bit
    logic [UTX_LEN_W-1:0]   r_bit,     w_bit;
    logic                   r_wave,    w_wave;

    logic [UTX_HP_W-1:0]    w_hp_last;
    logic [15:0]            w_pl_eff;
    logic [16:0]            w_hcyc_last;
    logic [UTX_LEN_W-1:0]   w_bit_last;

    // Zero half_period / pulse_len behave as 1.
    assign w_hp_last   = (i_cfg.half_period == '0) ? '0 : i_cfg.half_period - 1'b1;
    assign w_pl_eff    = (i_cfg.pulse_len == '0) ? 16'd1 : i_cfg.pulse_len;
    assign w_hcyc_last = {w_pl_eff, 1'b0} - 17'd1;
    assign w_bit_last  = i_cfg.pat_len - 1'b1;

    always_comb begin
        w_state   = r_state;
        w_dcnt    = r_dcnt;
        w_hcnt    = r_hcnt;
        w_carrier = r_carrier;
        w_hcyc    = r_hcyc;
        w_bit     = r_bit;
        w_wave    = 1'b0;
        if (i_clear) begin
            w_state   = CH_IDLE;
            w_dcnt    = '0;
            w_hcnt    = '0;
            w_carrier = 1'b0;
            w_hcyc    = '0;
            w_bit     = '0;
        end else begin
            case (r_state)
                CH_IDLE: begin
                    if (i_start) begin
                        w_state = CH_DELAY;
                        w_dcnt  = '0;
                    end
                end
                CH_DELAY: begin
                    if (r_dcnt == i_delay) begin
                        // Empty pattern: finish without ever driving.
                        w_state   = (i_cfg.pat_len == '0) ? CH_IDLE : CH_TX;
                        w_hcnt    = '0;
                        w_carrier = 1'b0;
                        w_hcyc    = '0;
                        w_bit     = '0;
                    end else begin
                        w_dcnt = r_dcnt + 1'b1;
                    end
                end
                CH_TX: begin
                    if (r_hcnt == w_hp_last) begin
                        w_hcnt    = '0;
                        w_carrier = ~r_carrier;
                        if (r_hcyc == w_hcyc_last) begin
                            w_hcyc = '0;
                            if (r_bit == w_bit_last) w_state = CH_IDLE;
                            else                     w_bit   = r_bit + 1'b1;
                        end else begin
                            w_hcyc = r_hcyc + 1'b1;
                        end
                    end else begin
                        w_hcnt = r_hcnt + 1'b1;
                    end
                end
                default: w_state = CH_IDLE;
            endcase
        end
        // Wave is registered from next-state values so it lines up with the state register.
        w_wave = (w_state == CH_TX) &&
                 ((i_cfg.pattern[w_bit[BIT_W-1:0]] ^ w_carrier) & i_cfg.mask[w_bit[BIT_W-1:0]]);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state   <= CH_IDLE;
            r_dcnt    <= '0;
            r_hcnt    <= '0;
            r_carrier <= 1'b0;
            r_hcyc    <= '0;
            r_bit     <= '0;
            r_wave    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_dcnt    <= w_dcnt;
            r_hcnt    <= w_hcnt;
            r_carrier <= w_carrier;
            r_hcyc    <= w_hcyc;
            r_bit     <= w_bit;
            r_wave    <= w_wave;
        end
    end

    assign o_busy = (r_state != CH_IDLE);
    assign o_wave = r_wave;

endmodule

// File: rtl/ultrasound_tx_array.sv
// ultrasound_tx_array: fires N_CH steered transducer channels every tx_period+1
// clocks with a BPSK / on-off pattern on a programmable carrier.
// Ports:
//   clk, rstn       clock, synchronous active-low reset
//   i_enable        run; low stops and clears everything on the next edge
//   i_pattern       per-bit carrier phase invert
//   i_mask          per-bit carrier on (1) / silent (0)
//   i_pat_len       bits per transmission, clamped to PAT_W
//   i_pulse_len     carrier periods per bit
//   i_half_period   carrier half-period in clocks
//   i_tx_period     fire interval minus one
//   i_delay         per-channel start delay, channel c at [c*DLY_W +: DLY_W]
//   o_wave          transducer drive, one bit per channel
//   o_busy          any channel in DELAY or TX
//   o_done          one-cycle pulse when the last channel finishes
//   o_overrun       one-cycle pulse when a fire is dropped because busy
// Optional (macro UTX_BURST_LIMIT_EN):
//   i_burst_cnt     accepted fires per enable session (0 = unlimited)
//   o_burst_done    limit reached; cleared by dropping enable
// Pattern and half-period widths follow utx_pkg because utx_cfg_t carries them.
module ultrasound_tx_array
    import utx_pkg::*;
#(
    parameter int N_CH  = UTX_N_CH,
    parameter int DLY_W = UTX_DLY_W
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_enable,
    input  logic [UTX_PAT_W-1:0]  i_pattern,
    input  logic [UTX_PAT_W-1:0]  i_mask,
    input  logic [UTX_LEN_W-1:0]  i_pat_len,
    input  logic [15:0]           i_pulse_len,
    input  logic [UTX_HP_W-1:0]   i_half_period,
    input  logic [31:0]           i_tx_period,
    input  logic [N_CH*DLY_W-1:0] i_delay,
`ifdef UTX_BURST_LIMIT_EN
    input  logic [15:0]           i_burst_cnt,
    output logic                  o_burst_done,
`endif
    output logic [N_CH-1:0]       o_wave,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_overrun
);

    logic [31:0]           r_per_cnt;
    logic                  r_busy_q;
    utx_cfg_t              r_cfg;
    logic [N_CH*DLY_W-1:0] r_delay;
    logic [N_CH-1:0]       w_ch_busy;
    logic                  w_busy;
    logic                  w_fire;
    logic                  w_accept;
    logic                  w_limit;

`ifdef UTX_BURST_LIMIT_EN
    logic [15:0] r_burst_n;

    assign w_limit      = (i_burst_cnt != '0) && (r_burst_n >= i_burst_cnt);
    assign o_burst_done = w_limit;

    always_ff @(posedge clk) begin
        if (!rstn || !i_enable) r_burst_n <= '0;
        else if (w_accept)      r_burst_n <= r_burst_n + 1'b1;
    end
`else
    assign w_limit = 1'b0;
`endif

    assign w_busy   = |w_ch_busy;
    assign w_fire   = i_enable && (r_per_cnt == '0) && !w_limit;
    assign w_accept = w_fire && !w_busy;

    // r_busy_q is cleared with everything else on disable, so an abort never yields done.
    always_ff @(posedge clk) begin
        if (!rstn || !i_enable) begin
            r_per_cnt <= '0;
            r_busy_q  <= 1'b0;
        end else begin
            r_per_cnt <= (r_per_cnt == i_tx_period) ? '0 : r_per_cnt + 1'b1;
            r_busy_q  <= w_busy;
        end
    end

    // Shadow config: only loaded when every channel is idle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cfg   <= '0;
            r_delay <= '0;
        end else if (w_accept) begin
            r_cfg.pattern     <= i_pattern;
            r_cfg.mask        <= i_mask;
            r_cfg.pat_len     <= utx_clamp_len(i_pat_len);
            r_cfg.pulse_len   <= i_pulse_len;
            r_cfg.half_period <= i_half_period;
            r_delay           <= i_delay;
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        utx_channel #(.DLY_W(DLY_W)) u_ch (
            .clk     (clk),
            .rstn    (rstn),
            .i_clear (!i_enable),
            .i_start (w_accept),
            .i_cfg   (r_cfg),
            .i_delay (r_delay[c*DLY_W +: DLY_W]),
            .o_busy  (w_ch_busy[c]),
            .o_wave  (o_wave[c])
        );
    end

    assign o_busy    = w_busy;
    assign o_done    = r_busy_q && !w_busy;
    assign o_overrun = w_fire && w_busy;

endmodule

// File: tb/tb_ultrasound_tx_array.sv
module tb_ultrasound_tx_array;

    localparam int MAXC = 100;

    logic        clk = 1'b0;
    logic        rstn;
    logic        enable;
    logic [31:0] pattern, mask;
    logic [5:0]  pat_len;
    logic [15:0] pulse_len;
    logic [7:0]  half_period;
    logic [31:0] tx_period;
    logic [47:0] delay;
    logic [3:0]  wave;
    logic        busy, done, overrun;
`ifdef UTX_BURST_LIMIT_EN
    logic [15:0] burst_cnt;
    logic        burst_done;
`endif

    int total = 0;
    int bad   = 0;

    // {wave[3:0], busy, done, overrun} per cycle; cycle 0 = first cycle enable is high
    logic [6:0] ov[0:MAXC-1];
    logic [6:0] xv[0:MAXC-1];

    ultrasound_tx_array dut (
        .clk          (clk),
        .rstn         (rstn),
        .i_enable     (enable),
        .i_pattern    (pattern),
        .i_mask       (mask),
        .i_pat_len    (pat_len),
        .i_pulse_len  (pulse_len),
        .i_half_period(half_period),
        .i_tx_period  (tx_period),
        .i_delay      (delay),
`ifdef UTX_BURST_LIMIT_EN
        .i_burst_cnt  (burst_cnt),
        .o_burst_done (burst_done),
`endif
        .o_wave       (wave),
        .o_busy       (busy),
        .o_done       (done),
        .o_overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic idle();
        @(posedge clk); #1;
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [31:0] p, input logic [31:0] m, input logic [5:0] len,
                           input logic [15:0] pl, input logic [7:0] hp, input logic [31:0] per,
                           input logic [47:0] d);
        pattern = p; mask = m; pat_len = len; pulse_len = pl;
        half_period = hp; tx_period = per; delay = d;
    endtask

    // Enable is low for cycles off_at..on_at-1; at chg_at the live config is scrambled.
    task automatic capture(input int n, input int off_at, input int on_at, input int chg_at);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            enable = (k >= off_at && k < on_at) ? 1'b0 : 1'b1;
            if (k == chg_at) begin
                pattern = ~pattern; mask = ~mask; pat_len = 6'd1; half_period = 8'd9;
            end
            @(negedge clk);
            ov[k] = {wave, busy, done, overrun};
        end
    endtask

    task automatic clear_exp();
        for (int k = 0; k < MAXC; k++) xv[k] = '0;
    endtask

    // Expected outputs for a transmission accepted in cycle f: DELAY lasts delay+1 cycles,
    // then nbits*bd TX cycles with carrier = (j/hpe) odd; done one cycle after busy ends.
    task automatic expect_tx(input int f, input logic [31:0] pat, input logic [31:0] msk,
                             input int nbits, input int bd, input int hpe,
                             input int d0, input int d1, input int d2, input int d3);
        int d[4];
        int dmax, nt, k;
        logic car;
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        dmax = 0;
        for (int c = 0; c < 4; c++) if (d[c] > dmax) dmax = d[c];
        nt = nbits * bd;
        for (int i = f + 1; i <= f + 1 + dmax + nt; i++) if (i < MAXC) xv[i][2] = 1'b1;
        if (f + 2 + dmax + nt < MAXC) xv[f + 2 + dmax + nt][1] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < nt; j++) begin
                k = f + 2 + d[c] + j;
                car = ((j / hpe) % 2) == 1;
                if (k < MAXC) xv[k][3 + c] = (pat[j / bd] ^ car) & msk[j / bd];
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        enable = 1'b1;
        set_cfg(32'h5, 32'hF, 6'd4, 16'd1, 8'd3, 32'd1000, 48'd0);
        repeat (3) @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if ({wave, busy, done, overrun} !== 7'd0) begin
                bad++;
                $display("FAIL reset got=%b exp=%b", {wave, busy, done, overrun}, 7'd0);
            end
        end
        @(posedge clk); #1;
        enable = 1'b0;
        rstn = 1'b1;
        idle();
    endtask

    task automatic test_basic();
        idle();
        set_cfg(32'b0101, 32'hF, 6'd4, 16'd1, 8'd3, 32'd1000, 48'd0);
        clear_exp();
        expect_tx(0, 32'b0101, 32'hF, 4, 6, 3, 0, 0, 0, 0);
        capture(30, -1, -1, 5);
        for (int k = 0; k < 30; k++) begin
            total++;
            if (ov[k] !== xv[k]) begin
                bad++;
                $display("FAIL basic k=%0d got wbdo=%b exp=%b", k, ov[k], xv[k]);
            end
        end
    endtask

    task automatic test_delay();
        idle();
        set_cfg(32'b0101, 32'hF, 6'd4, 16'd1, 8'd3, 32'd1000,
                {12'd15, 12'd10, 12'd5, 12'd0});
        clear_exp();
        expect_tx(0, 32'b0101, 32'hF, 4, 6, 3, 0, 5, 10, 15);
        capture(45, -1, -1, -1);
        for (int k = 0; k < 45; k++) begin
            total++;
            if (ov[k] !== xv[k]) begin
                bad++;
                $display("FAIL delay k=%0d got wbdo=%b exp=%b", k, ov[k], xv[k]);
            end
        end
    endtask

    task automatic test_overrun();
        idle();
        set_cfg(32'b0110, 32'hF, 6'd4, 16'd1, 8'd3, 32'd10, 48'd0);
        clear_exp();
        expect_tx(0, 32'b0110, 32'hF, 4, 6, 3, 0, 0, 0, 0);
        expect_tx(33, 32'b0110, 32'hF, 4, 6, 3, 0, 0, 0, 0);
        xv[11][0] = 1'b1; xv[22][0] = 1'b1; xv[44][0] = 1'b1; xv[55][0] = 1'b1;
        capture(57, -1, -1, -1);
        for (int k = 0; k < 57; k++) begin
            total++;
            if (ov[k] !== xv[k]) begin
                bad++;
                $display("FAIL overrun k=%0d got wbdo=%b exp=%b", k, ov[k], xv[k]);
            end
        end
    endtask

    task automatic test_mask_len0();
        idle();
        set_cfg(32'b0011, 32'b1010, 6'd4, 16'd1, 8'd3, 32'd1000, 48'd0);
        clear_exp();
        expect_tx(0, 32'b0011, 32'b1010, 4, 6, 3, 0, 0, 0, 0);
        capture(30, -1, -1, -1);
        for (int k = 0; k < 30; k++) begin
            total++;
            if (ov[k] !== xv[k]) begin
                bad++;
                $display("FAIL mask k=%0d got wbdo=%b exp=%b", k, ov[k], xv[k]);
            end
        end
        idle();
        set_cfg(32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd0, 16'd1, 8'd3, 32'd1000, 48'd0);
        clear_exp();
        xv[1] = 7'b0000_100;
        xv[2] = 7'b0000_010;
        capture(8, -1, -1, -1);
        for (int k = 0; k < 8; k++) begin
            total++;
            if (ov[k] !== xv[k]) begin
                bad++;
                $display("FAIL len0 k=%0d got wbdo=%b exp=%b", k, ov[k], xv[k]);
            end
        end
    endtask

    task automatic test_abort();
        idle();
        set_cfg(32'b1001, 32'hF, 6'd4, 16'd1, 8'd3, 32'd1000, 48'd0);
        clear_exp();
        expect_tx(0, 32'b1001, 32'hF, 4, 6, 3, 0, 0, 0, 0);
        for (int k = 11; k < MAXC; k++) xv[k] = '0;
        expect_tx(15, 32'b1001, 32'hF, 4, 6, 3, 0, 0, 0, 0);
        capture(45, 10, 15, -1);
        for (int k = 0; k < 45; k++) begin
            total++;
            if (ov[k] !== xv[k]) begin
                bad++;
                $display("FAIL abort k=%0d got wbdo=%b exp=%b", k, ov[k], xv[k]);
            end
        end
    endtask

    // pat_len above PAT_W clamps to 32 bits; zero half_period/pulse_len act as 1.
    task automatic test_clamp_min();
        idle();
        set_cfg(32'h0, 32'hFFFF_FFFF, 6'd63, 16'd0, 8'd0, 32'd1000, 48'd0);
        clear_exp();
        expect_tx(0, 32'h0, 32'hFFFF_FFFF, 32, 2, 1, 0, 0, 0, 0);
        capture(70, -1, -1, -1);
        for (int k = 0; k < 70; k++) begin
            total++;
            if (ov[k] !== xv[k]) begin
                bad++;
                $display("FAIL clamp k=%0d got wbdo=%b exp=%b", k, ov[k], xv[k]);
            end
        end
    endtask

    // tx_period=0 with an empty pattern: fire every cycle, accepted on the cycle done pulses.
    task automatic test_back_to_back();
        idle();
        set_cfg(32'hF, 32'hF, 6'd0, 16'd1, 8'd3, 32'd0, 48'd0);
        clear_exp();
        for (int k = 0; k < 10; k++) begin
            xv[k][2] = (k % 2) == 1;
            xv[k][1] = (k >= 2) && ((k % 2) == 0);
            xv[k][0] = (k % 2) == 1;
        end
        capture(10, -1, -1, -1);
        for (int k = 0; k < 10; k++) begin
            total++;
            if (ov[k] !== xv[k]) begin
                bad++;
                $display("FAIL b2b k=%0d got wbdo=%b exp=%b", k, ov[k], xv[k]);
            end
        end
    endtask

`ifdef UTX_BURST_LIMIT_EN
    task automatic test_burst();
        int starts;
        logic prev;
        idle();
        set_cfg(32'h1, 32'hF, 6'd0, 16'd1, 8'd3, 32'd100, 48'd0);
        burst_cnt = 16'd3;
        starts = 0;
        prev = 1'b0;
        for (int k = 0; k < 420; k++) begin
            @(posedge clk); #1;
            enable = 1'b1;
            @(negedge clk);
            if (busy && !prev) starts++;
            prev = busy;
        end
        total++;
        if (starts !== 3) begin
            bad++;
            $display("FAIL burst_count got=%0d exp=3", starts);
        end
        total++;
        if (burst_done !== 1'b1) begin
            bad++;
            $display("FAIL burst_done_set got=%b exp=1", burst_done);
        end
        idle();
        @(negedge clk);
        total++;
        if (burst_done !== 1'b0) begin
            bad++;
            $display("FAIL burst_done_clr got=%b exp=0", burst_done);
        end
        clear_exp();
        xv[1] = 7'b0000_100;
        xv[2] = 7'b0000_010;
        capture(4, -1, -1, -1);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (ov[k] !== xv[k]) begin
                bad++;
                $display("FAIL burst_restart k=%0d got wbdo=%b exp=%b", k, ov[k], xv[k]);
            end
        end
    endtask
`endif

    initial begin
        rstn = 1'b0;
        enable = 1'b0;
`ifdef UTX_BURST_LIMIT_EN
        burst_cnt = 16'd0;
`endif
        set_cfg(32'h0, 32'h0, 6'd0, 16'd0, 8'd0, 32'd0, 48'd0);
        test_reset();
        test_basic();
        test_delay();
        test_overrun();
        test_mask_len0();
        test_abort();
        test_clamp_min();
        test_back_to_back();
`ifdef UTX_BURST_LIMIT_EN
        test_burst();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
